// File: rtl/dir_input_queue.sv
// Button front-end for the snake core: sync, optional debounce (DIRQ_DEBOUNCE_EN), press priority,
// reversal filter and a small turn FIFO released one entry per game tick.
module dir_input_queue #(
  parameter int CLK_HZ      = 25_000_000,
  parameter int DEBOUNCE_MS = 10,
  parameter int DEPTH       = 2
) (
  input  logic       clk_pix,
  input  logic       reset,
  input  logic       up_n,
  input  logic       left_n,
  input  logic       down_n,
  input  logic       right_n,
  input  logic       tick,
  output logic [1:0] dir,
  output logic [2:0] queue_count,
  output logic       drop_evt
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [3:0]    btn_n;
  logic [3:0]    sync1, sync2, deb, deb_d, armed, press, losers;
  logic [1:0]    flush;
  logic [1:0]    req, ref_dir;
  logic          req_valid, pop, push, full, drop_nxt;
  logic [PW-1:0] rd_ptr, wr_ptr, tail_idx;
  logic [1:0]    fifo [DEPTH];

  // Bit index equals the direction code it requests.
  assign btn_n = {right_n, down_n, left_n, up_n};

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A button only arms once the refilled synchroniser shows it released, so a hold through reset is ignored.
  always_ff @(posedge clk_pix or posedge reset) begin
    if (reset) begin
      sync1 <= '1;
      sync2 <= '1;
      deb_d <= '1;
      armed <= '0;
      flush <= '0;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
      deb_d <= deb;
      flush <= (flush == 2'd2) ? flush : flush + 2'd1;
      armed <= armed | (sync2 & {4{flush == 2'd2}});
    end
  end

`ifdef DIRQ_DEBOUNCE_EN
  localparam int D_RAW = CLK_HZ / 1000 * DEBOUNCE_MS;
  localparam int D     = (D_RAW < 1) ? 1 : D_RAW;
  localparam int CW    = $clog2(D + 1);

  for (genvar i = 0; i < 4; i++) begin : g_deb
    logic [CW-1:0] cnt;
    logic          level;
    always_ff @(posedge clk_pix or posedge reset) begin
      if (reset) begin
        cnt   <= '0;
        level <= 1'b1;
      end else if (sync2[i] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(D - 1)) begin
        cnt   <= '0;
        level <= sync2[i];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
    assign deb[i] = level;
  end
`else
  assign deb = sync2;
`endif

  assign press = armed & deb_d & ~deb;

  always_comb begin
    req       = 2'd0;
    req_valid = |press;
    for (int i = 3; i >= 0; i--) begin
      if (press[i]) req = 2'(i);
    end
    losers = req_valid ? (press & ~(4'd1 << req)) : 4'd0;
  end

  // The newest queued turn is the reference, so reversals are judged against where the snake will be heading.
  assign tail_idx = (wr_ptr == '0) ? PW'(DEPTH - 1) : wr_ptr - 1'b1;
  assign ref_dir  = (queue_count != 3'd0) ? fifo[tail_idx] : dir;
  assign full     = (queue_count == 3'(DEPTH));
  assign pop      = tick && (queue_count != 3'd0);

  always_comb begin
    push     = 1'b0;
    drop_nxt = |losers;
    if (req_valid && (req != ref_dir)) begin
      if ((req == (ref_dir ^ 2'b10)) || (full && !pop)) drop_nxt = 1'b1;
      else push = 1'b1;
    end
  end

  always_ff @(posedge clk_pix or posedge reset) begin
    if (reset) begin
      dir         <= 2'd3;
      queue_count <= 3'd0;
      drop_evt    <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      for (int i = 0; i < DEPTH; i++) fifo[i] <= 2'd0;
    end else begin
      drop_evt <= drop_nxt;
      if (push) begin
        fifo[wr_ptr] <= req;
        wr_ptr       <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        dir    <= fifo[rd_ptr];
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (push && !pop)      queue_count <= queue_count + 3'd1;
      else if (pop && !push) queue_count <= queue_count - 3'd1;
    end
  end

endmodule

// File: doc/dir_input_queue.md
# dir_input_queue

Direction front-end between the four active-low push-buttons and the snake core. It synchronises and debounces the buttons and turns press edges into direction requests. Requests go into a small FIFO, and the block releases one queued turn per game tick. The result is that quick double-taps (e.g. up then right within one step) are both honoured, and reversals into the body are rejected. It replaces the combinational direction controller, drives the core's `dir` input, and is advanced by the gated run-tick.

## Interface
- `CLK_HZ`, default 25_000_000: pixel clock frequency.
- `DEBOUNCE_MS`, default 10: stable time required; D = CLK_HZ/1000*DEBOUNCE_MS cycles (D ≥ 1).
- `DEPTH`, default 2: FIFO entries, legal range 1..4.
- `clk_pix` input 1: pixel clock; sole clock.
- `reset` input 1: asynchronous, active-high reset.
- `up_n`, `left_n`, `down_n`, `right_n` input 1 each: raw asynchronous buttons, 0 = pressed.
- `tick` input 1: one-cycle step strobe; pops one entry.
- `dir` output 2: current direction: 0 = up, 1 = left, 2 = down, 3 = right.
- `queue_count` output 3: number of valid FIFO entries (0..DEPTH).
- `drop_evt` output 1: one-cycle pulse when a press is discarded.

## Operation
- Each button passes through a 2-FF synchroniser, then a debouncer (see Configuration), then a falling-edge detector on the debounced level, giving press pulse p_X.
- Simultaneous presses in one cycle: priority up > left > down > right. The winner is the request; every loser causes `drop_evt`.
- Reference direction R = FIFO tail entry if `queue_count` > 0, else `dir`.
- Request Q is evaluated against R:
  - Q == R: ignored silently (no push, no drop).
  - Q == R ^ 2'b10 (opposite): dropped, `drop_evt` = 1.
  - FIFO full (count == DEPTH) and no pop this cycle: dropped, `drop_evt` = 1.
  - Otherwise: pushed at the tail.
- On `tick` with count > 0: `dir` ← head entry, head pops, count decrements.
- On `tick` with count == 0: `dir` is unchanged.
- Push and pop in the same cycle:
  - Both take effect; count is unchanged.
  - A full FIFO accepts the push.
  - With count == 1, R is the entry being popped, which becomes `dir`, so the check stays consistent.
- There is no bypass: a request pushed in the same cycle as `tick` into an empty FIFO is applied on the next tick.
- The FIFO is a circular buffer with rd/wr pointers modulo DEPTH; count is a separate saturating-free counter.
- Reset (async, any time, including mid-debounce or with a full queue):
  - `dir` = 3 (right), `queue_count` = 0, `drop_evt` = 0.
  - Pointers are 0, debounce counters are 0, debounced levels are 1 (released), synchronisers are 1.
  - A button held through reset release generates no press until it is released and pressed again.

## Timing
- Button low before edge k: the synchroniser output is low after edge k+1.
- With debounce: the debounced level falls at edge k+1+D; the FIFO write and `queue_count` increment occur at edge k+2+D.
- Without debounce: the write occurs at edge k+2.
- `drop_evt` is asserted in the cycle after the debounced fall, i.e. registered together with the write edge.
- Pop latency: `dir` and `queue_count` update on the same edge that samples `tick` = 1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: `DIRQ_DEBOUNCE_EN`.
- Defined: one counter of ceil(log2(D+1)) bits per button.
  - Counting: the counter increments while the synchronised level differs from the debounced level, and resets to 0 when they match.
  - Update: reaching D updates the debounced level and clears the counter.
  - Glitches shorter than D cycles are rejected.
- Undefined: the debounced level equals the synchroniser output; the counters are not instantiated.
- Everything else is identical in both builds.

## Test plan
Bench parameters: CLK_HZ = 1000, DEBOUNCE_MS = 4, so D = 4.

- Reset release, no buttons, 3 ticks -> `dir` = 3, `queue_count` = 0, `drop_evt` never high.
- `up_n` low for 10 cycles from edge 0 (debounce build) -> `queue_count` = 1 at edge 6. Next `tick` -> `dir` = 0, count = 0.
- From `dir` = 3, press up then left, 10 cycles apart, before any tick -> count = 2. Tick 1 gives `dir` = 0; tick 2 gives `dir` = 1.
- From `dir` = 3, press left -> rejected, `drop_evt` one cycle, count stays 0. Press right -> ignored, no `drop_evt`.
- DEPTH = 2 full with [0, 1], then press down with no tick -> `drop_evt`, count 2. Same press landing on a `tick` cycle -> accepted, count 2, `dir` = 0.
- `up_n` glitch low for 3 cycles (debounce build) -> no push. Non-debounce build: same glitch pushes at edge 2. Assert `reset` mid-glitch -> all outputs return to reset values immediately.
